// File: rtl/mu_ram_1rw_pipe.sv
// Single-port synchronous RAM with byte-lane writes, 1/2-stage registered read with valid strobe,
// selectable read-during-write behaviour and an optional zero-fill sequence after reset.
//   state   | meaning
//   S_CLEAR | zero-fill, one word per cycle, busy=1, requests dropped
//   S_IDLE  | serving read/write requests
module mu_ram_1rw_pipe #(
    parameter int DW         = 8,
    parameter int AW         = 12,
    parameter int BW         = 8,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW/BW-1:0]  be,
    input  logic [DW-1:0]     wr,
    output logic [DW-1:0]     rd,
    output logic              rd_valid,
    output logic              busy
);
    localparam int NB = DW / BW;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t state, state_nxt;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_lane_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] old_word, merged_word, rd_src;
    logic          accept, s1_load;
    logic          v1, v_out;
    logic [DW-1:0] d1;

    always_ff @(posedge clk) begin
        if (rst) state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_addr == LAST_ADDR) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Holds at the terminal count instead of wrapping; the FSM leaves CLEAR on that word.
    always_ff @(posedge clk) begin
        if (rst)
            clr_addr <= '0;
        else if (state == S_CLEAR && clr_addr != LAST_ADDR)
            clr_addr <= clr_addr + AW'(1);
    end

    assign accept = (state == S_IDLE) && req;

    always_comb begin
        mem_addr    = addr;
        mem_lane_we = '0;
        mem_wdata   = wr;
        if (state == S_CLEAR) begin
            mem_addr    = clr_addr;
            mem_lane_we = '1;
            mem_wdata   = '0;
        end else if (accept && we) begin
            mem_lane_we = be;
        end
        if (rst) mem_lane_we = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (mem_lane_we[i]) mem[mem_addr][i*BW +: BW] <= mem_wdata[i*BW +: BW];
    end

    always_comb begin
        old_word    = mem[addr];
        merged_word = old_word;
        for (int i = 0; i < NB; i++)
            if (be[i]) merged_word[i*BW +: BW] = wr[i*BW +: BW];
        rd_src  = (WR_MODE == 1 && we) ? merged_word : old_word;
        s1_load = accept && (!we || WR_MODE != 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= s1_load;
            if (s1_load) d1 <= rd_src;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          v2;
            logic [DW-1:0] d2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign v_out = v2;
            assign rd    = d2;
        end else begin : g_lat1
            assign v_out = v1;
            assign rd    = d1;
        end
    endgenerate

    // Masked by rst so a strobe registered before reset never shows during reset.
    assign rd_valid = v_out && !rst;

endmodule

// File: tb/tb_mu_ram_1rw_pipe.sv
// Three RAM configurations driven by identical stimulus, checked against a word-array model
// with per-configuration latency and read-during-write rules.
module tb_mu_ram_1rw_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [3:0]  addr = '0;
    logic [1:0]  be = '0;
    logic [15:0] wr = '0;
    logic [15:0] rd_o [3];
    logic        rdv [3];
    logic        busy_o [3];

    int checks = 0, errors = 0;
    int cyc = 0;

    // model state
    logic [15:0] mm [16];
    int          clr_left = 0;
    logic        sv [3][8];
    logic [15:0] sd [3][8];
    logic        exp_v [3];
    logic [15:0] exp_d [3];
    logic        exp_busy;

    mu_ram_1rw_pipe #(.DW(16), .AW(4), .BW(8), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wr(wr),
        .rd(rd_o[0]), .rd_valid(rdv[0]), .busy(busy_o[0]));
    mu_ram_1rw_pipe #(.DW(16), .AW(4), .BW(8), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(1)) u_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wr(wr),
        .rd(rd_o[1]), .rd_valid(rdv[1]), .busy(busy_o[1]));
    mu_ram_1rw_pipe #(.DW(16), .AW(4), .BW(8), .RD_LAT(1), .WR_MODE(2), .CLR_ON_RST(1)) u_c (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wr(wr),
        .rd(rd_o[2]), .rd_valid(rdv[2]), .busy(busy_o[2]));

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, then sample #1 after the edge.
    task automatic tick(input logic r, input logic q, input logic w, input logic [3:0] a,
                        input logic [1:0] b, input logic [15:0] d);
        logic [15:0] old_w, mrg;
        int due;
        rst = r; req = q; we = w; addr = a; be = b; wr = d;
        if (r) begin
            clr_left = 16;
            for (int k = 0; k < 3; k++) begin
                exp_d[k] = '0;
                for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
            end
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) for (int i = 0; i < 16; i++) mm[i] = '0;
        end else if (q) begin
            old_w = mm[a];
            mrg   = old_w;
            if (w) begin
                if (b[0]) mrg[7:0]  = d[7:0];
                if (b[1]) mrg[15:8] = d[15:8];
                mm[a] = mrg;
            end
            for (int k = 0; k < 3; k++) begin
                if (!w || k != 0) begin
                    due = cyc + lat_of(k);
                    sv[k][due % 8] = 1'b1;
                    sd[k][due % 8] = (w && k == 1) ? mrg : old_w;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_v[k] = sv[k][cyc % 8];
            if (exp_v[k]) exp_d[k] = sd[k][cyc % 8];
            sv[k][cyc % 8] = 1'b0;
        end
        exp_busy = (clr_left > 0);
    endtask

    task automatic test_reset();
        int n;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_o[k] !== 1'b1 || rdv[k] !== 1'b0 || rd_o[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b rd_valid=%b rd=%h, expected 1 0 0000",
                         k, busy_o[k], rdv[k], rd_o[k]);
            end
        end
        n = 0;
        while (busy_o[0] === 1'b1 && n < 40) begin
            tick(0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != 16 || busy_o[1] !== 1'b0 || busy_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL clear_len: busy cycles=%0d busy1=%b busy2=%b, expected 16 0 0",
                     n, busy_o[1], busy_o[2]);
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a <= 16; a++) begin
            tick(0, a < 16, 0, 4'(a), 2'b00, 16'h0);
            if (a < 16) begin
                checks++;
                if (rdv[0] !== 1'b1 || rd_o[0] !== 16'h0 || rdv[2] !== 1'b1 || rd_o[2] !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_read addr%0d: lat1 rd_valid=%b/%b rd=%h/%h, expected 1 0000",
                             a, rdv[0], rdv[2], rd_o[0], rd_o[2]);
                end
            end
            if (a >= 1) begin
                checks++;
                if (rdv[1] !== 1'b1 || rd_o[1] !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_read_lat2 addr%0d: rd_valid=%b rd=%h, expected 1 0000",
                             a - 1, rdv[1], rd_o[1]);
                end
            end
        end
    endtask

    task automatic test_byte_enables();
        tick(0, 1, 1, 4'd3, 2'b11, 16'hABCD);
        tick(0, 1, 1, 4'd3, 2'b01, 16'h1234);
        tick(0, 1, 1, 4'd3, 2'b00, 16'hFFFF);
        tick(0, 1, 0, 4'd3, 2'b00, 16'h0);
        checks++;
        if (rdv[0] !== 1'b1 || rd_o[0] !== 16'hAB34 || rdv[2] !== 1'b1 || rd_o[2] !== 16'hAB34) begin
            errors++;
            $display("FAIL byte_en lat1: rd=%h/%h valid=%b/%b, expected AB34 1",
                     rd_o[0], rd_o[2], rdv[0], rdv[2]);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (rdv[1] !== 1'b1 || rd_o[1] !== 16'hAB34) begin
            errors++;
            $display("FAIL byte_en lat2: rd=%h valid=%b, expected AB34 1", rd_o[1], rdv[1]);
        end
    endtask

    task automatic test_latency();
        logic        v_seen [5];
        logic [15:0] d_seen [5];
        logic        v_req  [5];
        logic [15:0] d_req  [5];
        tick(0, 1, 1, 4'd0, 2'b11, 16'h0011);
        tick(0, 1, 1, 4'd1, 2'b11, 16'h0022);
        tick(0, 1, 1, 4'd2, 2'b11, 16'h0033);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            tick(0, t < 3, 0, 4'(t), 2'b00, 16'h0);
            v_seen[t] = rdv[1];
            d_seen[t] = rd_o[1];
        end
        v_req = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        d_req = '{16'h0033, 16'h0011, 16'h0022, 16'h0033, 16'h0033};
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (v_seen[t] !== v_req[t] || d_seen[t] !== d_req[t]) begin
                errors++;
                $display("FAIL latency2 cycle%0d: rd_valid=%b rd=%h, expected %b %h",
                         t, v_seen[t], d_seen[t], v_req[t], d_req[t]);
            end
        end
    endtask

    task automatic test_wr_mode();
        logic [15:0] held;
        tick(0, 1, 1, 4'd5, 2'b11, 16'h000F);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        held = rd_o[0];
        tick(0, 1, 1, 4'd5, 2'b11, 16'h00F0);
        checks++;
        if (rdv[0] !== 1'b0 || rd_o[0] !== held) begin
            errors++;
            $display("FAIL wr_mode0: rd_valid=%b rd=%h, expected 0 %h", rdv[0], rd_o[0], held);
        end
        checks++;
        if (rdv[2] !== 1'b1 || rd_o[2] !== 16'h000F) begin
            errors++;
            $display("FAIL wr_mode2: rd_valid=%b rd=%h, expected 1 000f", rdv[2], rd_o[2]);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (rdv[1] !== 1'b1 || rd_o[1] !== 16'h00F0 || rdv[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_mode1: rd_valid=%b rd=%h mode0 valid=%b, expected 1 00f0 0",
                     rdv[1], rd_o[1], rdv[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        for (int t = 0; t < 400; t++) begin
            r = ($urandom_range(0, 79) == 0);
            tick(r, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdv[k] !== exp_v[k] || rd_o[k] !== exp_d[k] || busy_o[k] !== exp_busy) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: rd_valid=%b rd=%h busy=%b, expected %b %h %b",
                             k, cyc, rdv[k], rd_o[k], busy_o[k], exp_v[k], exp_d[k], exp_busy);
                end
            end
        end
        for (int t = 0; t < 40 && busy_o[0] !== 1'b0; t++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_clear();
        int  n;
        logic any_v;
        tick(0, 1, 0, 4'd5, 2'b00, 16'h0);
        checks++;
        if (rdv[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL pre_flush: rd_valid=%b busy=%b, expected 1 0", rdv[0], busy_o[0]);
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (rdv[0] !== 1'b0 || rdv[1] !== 1'b0 || rdv[2] !== 1'b0 || rd_o[1] !== 16'h0) begin
            errors++;
            $display("FAIL flush: rd_valid=%b%b%b rd_lat2=%h, expected 000 0000",
                     rdv[0], rdv[1], rdv[2], rd_o[1]);
        end
        for (int t = 0; t < 7; t++) tick(0, 1, 1, 4'd9, 2'b11, 16'hFFFF);
        tick(1, 1, 1, 4'd9, 2'b11, 16'hFFFF);
        checks++;
        if (busy_o[0] !== 1'b1 || rdv[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_rst: busy=%b rd_valid=%b, expected 1 0", busy_o[0], rdv[0]);
        end
        n = 0;
        while (busy_o[0] === 1'b1 && n < 40) begin
            tick(0, 1, 1'(n), 4'd9, 2'b11, 16'hFFFF);
            n++;
            any_v = rdv[0] | rdv[1] | rdv[2];
            checks++;
            if (any_v !== 1'b0) begin
                errors++;
                $display("FAIL busy_req cycle%0d: rd_valid=%b%b%b, expected 000", n, rdv[0], rdv[1], rdv[2]);
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL restart_len: busy cycles=%0d, expected 16", n);
        end
        tick(0, 1, 0, 4'd9, 2'b00, 16'h0);
        checks++;
        if (rdv[0] !== 1'b1 || rd_o[0] !== 16'h0 || rdv[2] !== 1'b1 || rd_o[2] !== 16'h0) begin
            errors++;
            $display("FAIL busy_req_mem: rd_valid=%b rd=%h, expected 1 0000", rdv[0], rd_o[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_v[k] = 1'b0;
            exp_d[k] = '0;
            for (int s = 0; s < 8; s++) begin
                sv[k][s] = 1'b0;
                sd[k][s] = '0;
            end
        end
        for (int i = 0; i < 16; i++) mm[i] = '0;
        exp_busy = 1'b1;
        test_reset();
        test_clear_reads();
        test_byte_enables();
        test_latency();
        test_wr_mode();
        test_back_to_back();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
